pseudo_sensor_frame_ctrl: RTL and testbench
===========================================

Name: pseudo_sensor_frame_ctrl

Overview:
Frame-timing controller for the pseudo sensor. It sequences one or more synthetic frames of H_ACTIVE x V_ACTIVE pixels and generates the sof/de strobes that drive the linear address generator and the frame-buffer read path. It adds horizontal and vertical blanking, so downstream LeNet-5 input logic sees sensor-like timing. Software-side control is a start/stop handshake with single, N-frame or continuous modes.

Parameters:
H_ACTIVE, 32, active pixels per line (>=1)
V_ACTIVE, 32, active lines per frame (>=1)
H_BLANK, 8, idle cycles between lines (>=1)
V_BLANK, 16, idle cycles after the last line (>=1)
CNT_WIDTH, 12, width of the x/y counters; must hold max(H_ACTIVE, V_ACTIVE, H_BLANK, V_BLANK)
FRM_WIDTH, 8, width of the frame counters

Ports:
p_clk  in  1  pixel clock; the only clock
srst_p  in  1  synchronous active-high reset
start  in  1  start request; sampled only in IDLE
stop  in  1  request to halt at the next frame boundary
continuous  in  1  1 = run until stop; latched on start accept
num_frames  in  FRM_WIDTH  frames per run when continuous=0; latched on start accept; 0 is treated as 1
busy  out  1  high in every state except IDLE
sof  out  1  one-cycle start-of-frame pulse (resets the address generator)
de  out  1  pixel valid (address generator increments)
eol  out  1  high with de on the last pixel of each line
eof  out  1  high with de on the last pixel of the frame
x  out  CNT_WIDTH  pixel column while de=1, else 0
y  out  CNT_WIDTH  line index during ACTIVE/HBLANK, else 0
frame_done  out  1  one-cycle pulse on the last VBLANK cycle
frames_sent  out  FRM_WIDTH  frames completed in the current run; wraps modulo 2^FRM_WIDTH

Behaviour:
- All outputs are registered and are Moore-decoded from state plus counters.
- srst_p is high at a rising edge: on the next edge, state=IDLE, all outputs=0, and the latched mode, stop_pending and all counters clear. This applies even mid-frame; there is no partial-frame completion.
- States are IDLE, SOF, ACTIVE, HBLANK and VBLANK.
- IDLE:
  - start=1 is accepted. It latches continuous and num_frames (0 becomes 1), clears frames_sent and goes to SOF.
  - stop is ignored in IDLE.
- SOF:
  - Lasts exactly 1 cycle: sof=1, de=0, busy=1.
  - Then ACTIVE with x=0, y=0.
- ACTIVE:
  - de=1 for H_ACTIVE consecutive cycles; x counts 0..H_ACTIVE-1.
  - eol=1 when x=H_ACTIVE-1.
  - On the last pixel: if y<V_ACTIVE-1, go to HBLANK. Otherwise eof=1 (coincident with eol) and go to VBLANK.
- HBLANK:
  - Lasts H_BLANK cycles with de=0, x=0 and y held.
  - Then ACTIVE with y+1.
- VBLANK:
  - Lasts V_BLANK cycles with x=y=0.
  - On the last cycle: frame_done=1, and frames_sent increments on the following edge.
  - Exit priority:
    1. stop_pending goes to IDLE.
    2. continuous=1 goes to SOF.
    3. frames_sent+1 < latched num_frames goes to SOF.
    4. Otherwise go to IDLE.
  - Frames are back-to-back: the next SOF immediately follows VBLANK.
- stop handling:
  - stop=1 in any busy state sets stop_pending, which holds until IDLE entry and then clears.
  - stop in the same cycle as the final VBLANK cycle is counted and ends the run after this frame.
  - The current frame always finishes; stop never truncates de.
- start while busy is ignored; there is no queuing.
- start and stop in the same IDLE cycle: start is accepted and stop is ignored.
- Frame period = 1 + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK cycles. With the default parameters this is 1289 cycles.
- With sof as the reset and de as the increment of the address generator, the generated addresses span 0..H_ACTIVE*V_ACTIVE-1 per frame.
- busy drops on the edge after the final VBLANK cycle, i.e. one cycle after frame_done.

Test Plan:
Parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_BLANK=3 (period 20).
1. Reset, then start pulse with num_frames=1, continuous=0 -> sof at cycle 1; de high cycles 2-5, 8-11, 14-17; eol on 5/11/17; eof on 17; frame_done on 20; busy low from 21; frames_sent=1; 12 de pulses total.
2. num_frames=3, continuous=0 -> three contiguous 20-cycle frames; sof at cycles 1, 21, 41; frame_done at 20, 40, 60; frames_sent ends at 3; busy low at 61.
3. continuous=1, stop pulsed mid-line of frame 2 -> frame 2 completes all 12 de cycles; no third sof; IDLE after frame 2's VBLANK; frames_sent=2.
4. start pulsed during ACTIVE, and num_frames=0 -> the restart is ignored with no glitch on sof/de; num_frames=0 runs exactly 1 frame.
5. srst_p asserted during HBLANK of line 1, for 1 cycle -> next edge: busy=sof=de=0, x=y=0, frames_sent=0; a subsequent start produces a full clean frame from y=0.
6. Simultaneous start and stop in IDLE -> run starts; stop ignored; with num_frames=2, both frames are produced.

Source files
------------

// File: rtl/pseudo_sensor_frame_ctrl_if.sv
// Control/timing bundle for the pseudo sensor frame-timing controller.
//   start/stop/continuous/num_frames : run control from the software side
//   busy/sof/de/eol/eof/x/y          : frame timing toward the address generator
//   frame_done/frames_sent           : per-frame completion status
// master = run-control side, slave = the frame controller.
interface pseudo_sensor_frame_ctrl_if #(
  parameter int CNT_WIDTH = 12,
  parameter int FRM_WIDTH = 8
);
  logic                 start;
  logic                 stop;
  logic                 continuous;
  logic [FRM_WIDTH-1:0] num_frames;
  logic                 busy;
  logic                 sof;
  logic                 de;
  logic                 eol;
  logic                 eof;
  logic [CNT_WIDTH-1:0] x;
  logic [CNT_WIDTH-1:0] y;
  logic                 frame_done;
  logic [FRM_WIDTH-1:0] frames_sent;

  modport master (
    output start, stop, continuous, num_frames,
    input  busy, sof, de, eol, eof, x, y, frame_done, frames_sent
  );

  modport slave (
    input  start, stop, continuous, num_frames,
    output busy, sof, de, eol, eof, x, y, frame_done, frames_sent
  );
endinterface

// File: rtl/pseudo_sensor_frame_ctrl.sv
// Frame-timing controller for the pseudo sensor: sequences H_ACTIVE x V_ACTIVE
// synthetic frames with horizontal/vertical blanking, emitting sof/de strobes
// for the linear address generator and frame-buffer read path.
// Ports:
//   p_clk  : pixel clock
//   srst_p : synchronous active-high reset
//   bus    : control/timing bundle (slave side), see pseudo_sensor_frame_ctrl_if
module pseudo_sensor_frame_ctrl #(
  parameter int H_ACTIVE  = 32,
  parameter int V_ACTIVE  = 32,
  parameter int H_BLANK   = 8,
  parameter int V_BLANK   = 16,
  parameter int CNT_WIDTH = 12,
  parameter int FRM_WIDTH = 8
) (
  input  logic                        p_clk,
  input  logic                        srst_p,
  pseudo_sensor_frame_ctrl_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] HB_LAST = CNT_WIDTH'(H_BLANK - 1);
  localparam logic [CNT_WIDTH-1:0] VB_LAST = CNT_WIDTH'(V_BLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;       // x in ACTIVE, blank-cycle count in HBLANK/VBLANK
  logic [CNT_WIDTH-1:0] y_q;
  logic [FRM_WIDTH-1:0] frames_q;
  logic [FRM_WIDTH-1:0] nfrm_q;
  logic                 cont_q;
  logic                 stop_pend_q;

  logic                 stop_now;
  logic                 more_frames;
  logic [FRM_WIDTH:0]   frames_inc;

  // State and counter registers
  always_ff @(posedge p_clk) begin
    if (srst_p) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      frames_q    <= '0;
      nfrm_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // Every state change restarts the shared counter at zero.
      if (state_d != state_q || state_q == S_IDLE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CNT_WIDTH'(1);

      if (state_q == S_HBLANK && state_d == S_ACTIVE)
        y_q <= y_q + CNT_WIDTH'(1);
      else if (!(state_d == S_ACTIVE || state_d == S_HBLANK))
        y_q <= '0;

      if (state_q == S_IDLE && bus.start) begin
        cont_q   <= bus.continuous;
        nfrm_q   <= (bus.num_frames == '0) ? FRM_WIDTH'(1) : bus.num_frames;
        frames_q <= '0;
      end else if (state_q == S_VBLANK && cnt_q == VB_LAST) begin
        frames_q <= frames_q + FRM_WIDTH'(1);
      end

      if (state_d == S_IDLE)
        stop_pend_q <= 1'b0;
      else if (state_q != S_IDLE && bus.stop)
        stop_pend_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    // A stop arriving on the final VBLANK cycle still ends the run.
    stop_now    = stop_pend_q | bus.stop;
    frames_inc  = {1'b0, frames_q} + (FRM_WIDTH + 1)'(1);
    more_frames = frames_inc < {1'b0, nfrm_q};
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SOF;
      S_SOF:    state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (cnt_q == H_LAST)
          state_d = (y_q == V_LAST) ? S_VBLANK : S_HBLANK;
      end
      S_HBLANK: if (cnt_q == HB_LAST) state_d = S_ACTIVE;
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (stop_now)         state_d = S_IDLE;
          else if (cont_q)      state_d = S_SOF;
          else if (more_frames) state_d = S_SOF;
          else                  state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode from registered state and counters
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.sof         = (state_q == S_SOF);
    bus.de          = (state_q == S_ACTIVE);
    bus.eol         = 1'b0;
    bus.eof         = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    bus.frame_done  = 1'b0;
    bus.frames_sent = frames_q;
    if (state_q == S_ACTIVE) begin
      bus.x   = cnt_q;
      bus.eol = (cnt_q == H_LAST);
      bus.eof = (cnt_q == H_LAST) && (y_q == V_LAST);
    end
    if (state_q == S_ACTIVE || state_q == S_HBLANK)
      bus.y = y_q;
    if (state_q == S_VBLANK)
      bus.frame_done = (cnt_q == VB_LAST);
  end

endmodule

// File: tb/tb_pseudo_sensor_frame_ctrl.sv
// Self-checking bench for pseudo_sensor_frame_ctrl with small frame geometry.
module tb_pseudo_sensor_frame_ctrl;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int HB  = 2;
  localparam int VB  = 3;
  localparam int CW  = 12;
  localparam int FW  = 8;
  localparam int PER = 1 + V * H + (V - 1) * HB + VB;  // 20
  localparam int OW  = 6 + 2 * CW + FW;

  typedef logic [OW-1:0] ovec_t;

  logic p_clk  = 1'b0;
  logic srst_p = 1'b1;

  pseudo_sensor_frame_ctrl_if #(.CNT_WIDTH(CW), .FRM_WIDTH(FW)) bus ();

  pseudo_sensor_frame_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .H_BLANK  (HB),
    .V_BLANK  (VB),
    .CNT_WIDTH(CW),
    .FRM_WIDTH(FW)
  ) dut (
    .p_clk (p_clk),
    .srst_p(srst_p),
    .bus   (bus)
  );

  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_err    = 0;
  int sof_cnt, de_cnt, fd_cnt;
  bit model_valid = 1'b0;

  // Reference model: run position expressed as offset within the frame period
  bit m_busy, m_cont, m_stop;
  int m_o, m_frames, m_nfrm;

  function automatic ovec_t exp_vec();
    bit busy, sof, de, eol, eof, fd;
    int x, y, p, line, col;
    busy = m_busy; sof = 0; de = 0; eol = 0; eof = 0; fd = 0; x = 0; y = 0;
    if (m_busy) begin
      if (m_o == 0) sof = 1;
      else if (m_o >= PER - VB) fd = (m_o == PER - 1);
      else begin
        p    = m_o - 1;
        line = p / (H + HB);
        col  = p % (H + HB);
        y    = line;
        if (col < H) begin
          de  = 1;
          x   = col;
          eol = (col == H - 1);
          eof = eol && (line == V - 1);
        end
      end
    end
    return {busy, sof, de, eol, eof, fd, CW'(x), CW'(y), FW'(m_frames)};
  endfunction

  function automatic ovec_t dut_vec();
    return {bus.busy, bus.sof, bus.de, bus.eol, bus.eof, bus.frame_done,
            bus.x, bus.y, bus.frames_sent};
  endfunction

  task automatic model_step(input bit rst, st, sp, ct, input logic [FW-1:0] nf);
    if (rst) begin
      m_busy = 0; m_o = 0; m_frames = 0; m_cont = 0; m_nfrm = 0; m_stop = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_o = 0; m_frames = 0; m_cont = ct; m_stop = 0;
        m_nfrm = (nf == 0) ? 1 : int'(nf);
      end
    end else begin
      if (sp) m_stop = 1;
      if (m_o == PER - 1) begin
        m_frames++;
        m_o = 0;
        if (m_stop || (!m_cont && m_frames >= m_nfrm)) begin
          m_busy = 0;
          m_stop = 0;
        end
      end else begin
        m_o++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic do_cycle(input bit rst, st, sp, ct, input logic [FW-1:0] nf);
    srst_p         = rst;
    bus.start      = st;
    bus.stop       = sp;
    bus.continuous = ct;
    bus.num_frames = nf;
    if (model_valid) begin
      chk("cycle", 64'(dut_vec()), 64'(exp_vec()));
      sof_cnt += int'(bus.sof);
      de_cnt  += int'(bus.de);
      fd_cnt  += int'(bus.frame_done);
    end
    @(posedge p_clk);
    model_step(rst, st, sp, ct, nf);
    model_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, '0);
  endtask

  task automatic clr_counts();
    sof_cnt = 0; de_cnt = 0; fd_cnt = 0;
  endtask

  typedef struct {
    bit st, sp, ct;
    logic [FW-1:0] nf;
    bit busy, sof, de, eol, eof, fd;
    int x, y, fs;
  } vec_t;

  function automatic vec_t mk(bit st, bit ct, int nf, bit busy, bit sof, bit de,
                              bit eol, bit eof, bit fd, int x, int y, int fs);
    vec_t r;
    r.st = st; r.sp = 0; r.ct = ct; r.nf = FW'(nf);
    r.busy = busy; r.sof = sof; r.de = de; r.eol = eol; r.eof = eof; r.fd = fd;
    r.x = x; r.y = y; r.fs = fs;
    return r;
  endfunction

  vec_t tbl[23];

  initial begin
    // Single-frame reference timeline: start in row 0, one row per cycle.
    //            st ct nf busy sof de eol eof fd  x  y fs
    tbl[0]  = mk(1, 0, 1,  0,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  1,  1, 0, 0,  0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 2, 0, 0);
    tbl[5]  = mk(0, 0, 0,  1,  0, 1, 1,  0,  0, 3, 0, 0);
    tbl[6]  = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 1, 1, 0);
    tbl[10] = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 2, 1, 0);
    tbl[11] = mk(0, 0, 0,  1,  0, 1, 1,  0,  0, 3, 1, 0);
    tbl[12] = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 0, 2, 0);
    tbl[15] = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 1, 2, 0);
    tbl[16] = mk(0, 0, 0,  1,  0, 1, 0,  0,  0, 2, 2, 0);
    tbl[17] = mk(0, 0, 0,  1,  0, 1, 1,  1,  0, 3, 2, 0);
    tbl[18] = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0,  1,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0,  1,  0, 0, 0,  0,  1, 0, 0, 0);
    tbl[21] = mk(0, 0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 1);
    tbl[22] = mk(0, 0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 1);

    bus.start = 0; bus.stop = 0; bus.continuous = 0; bus.num_frames = '0;

    do_cycle(1, 0, 0, 0, '0);
    do_cycle(1, 0, 0, 0, '0);

    // Scenario 1: table-driven single frame
    clr_counts();
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("tbl_row%0d", i), 64'(dut_vec()),
          64'({tbl[i].busy, tbl[i].sof, tbl[i].de, tbl[i].eol, tbl[i].eof, tbl[i].fd,
               CW'(tbl[i].x), CW'(tbl[i].y), FW'(tbl[i].fs)}));
      do_cycle(0, tbl[i].st, tbl[i].sp, tbl[i].ct, tbl[i].nf);
    end
    chk("s1_de_count", 64'(de_cnt), 64'(12));

    // Scenario 2: three back-to-back frames
    idle(3);
    clr_counts();
    do_cycle(0, 1, 0, 0, 8'd3);
    idle(61);
    chk("s2_sof_count", 64'(sof_cnt), 64'(3));
    chk("s2_fd_count", 64'(fd_cnt), 64'(3));
    chk("s2_frames_sent", 64'(bus.frames_sent), 64'(3));
    chk("s2_busy_low", 64'(bus.busy), 64'(0));

    // Scenario 3: continuous, stop mid-line in frame 2
    idle(2);
    clr_counts();
    do_cycle(0, 1, 0, 1, '0);
    idle(22);
    do_cycle(0, 0, 1, 1, '0);
    idle(40);
    chk("s3_sof_count", 64'(sof_cnt), 64'(2));
    chk("s3_de_count", 64'(de_cnt), 64'(24));
    chk("s3_frames_sent", 64'(bus.frames_sent), 64'(2));
    chk("s3_busy_low", 64'(bus.busy), 64'(0));

    // Scenario 4: num_frames=0 runs one frame, restart during ACTIVE ignored
    idle(2);
    clr_counts();
    do_cycle(0, 1, 0, 0, 8'd0);
    idle(2);
    do_cycle(0, 1, 0, 0, 8'd5);
    idle(30);
    chk("s4_sof_count", 64'(sof_cnt), 64'(1));
    chk("s4_de_count", 64'(de_cnt), 64'(12));
    chk("s4_frames_sent", 64'(bus.frames_sent), 64'(1));

    // Scenario 5: reset during HBLANK of line 1
    idle(2);
    do_cycle(0, 1, 0, 0, 8'd1);
    idle(11);
    do_cycle(1, 0, 0, 0, '0);
    chk("s5_after_reset", 64'(dut_vec()), 64'(0));
    clr_counts();
    do_cycle(0, 1, 0, 0, 8'd1);
    idle(22);
    chk("s5_sof_count", 64'(sof_cnt), 64'(1));
    chk("s5_de_count", 64'(de_cnt), 64'(12));
    chk("s5_frames_sent", 64'(bus.frames_sent), 64'(1));

    // Scenario 6: start and stop together in IDLE
    idle(2);
    clr_counts();
    do_cycle(0, 1, 1, 0, 8'd2);
    idle(42);
    chk("s6_sof_count", 64'(sof_cnt), 64'(2));
    chk("s6_frames_sent", 64'(bus.frames_sent), 64'(2));
    chk("s6_busy_low", 64'(bus.busy), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 249) == 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 3) == 0),
               FW'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
